sd_switch: RTL and testbench

- Multi-image SPI SD router between the core's SPI master and either the physical SD slot or one of NUM_IMG virtual sd_card instances.
- Parametrised successor of the single-image virtual/physical SD select logic in the emu top level.
- Adds three things over that logic:
  - per-slot mount/eject handling;
  - transaction-safe switching, where selection changes only while core SS is high;
  - retriggerable mount reset pulse and split activity LEDs.
- Sits in emu between hps_io and tsconf/sd_card, in the clk_sys domain.

---
 rtl/sd_switch_pkg.sv | 41 ++++
 rtl/sd_switch_act_timer.sv | 70 +++++++
 rtl/sd_switch.sv | 160 ++++++++++++++++
 tb/tb_sd_switch.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/sd_switch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sd_switch_pkg
//  Description : Shared types, constants and helpers for the multi-image
//                SPI SD router (sd_switch) and its timer sub-block.
//  Revision    : 1.0  initial release
// ============================================================================
package sd_switch_pkg;

    // Upper bound on image slots and the selection index width that covers it
    localparam int c_slot_max        = 8;
    localparam int c_sel_idx_w       = 3;

    // Default timing constants (clk_sys cycles) and counter width
    localparam int c_def_act_timeout = 1000000;
    localparam int c_def_rst_hold    = 10000000;
    localparam int c_def_cnt_w       = 24;

    // sd_act_timer operating modes
    localparam int c_mode_act        = 0;  // clear on event, count up, saturate
    localparam int c_mode_hold       = 1;  // load on event, count down to zero

    // Routing selection: valid=0 means the physical card is routed
    typedef struct packed {
        logic                   valid;
        logic [c_sel_idx_w-1:0] idx;
    } sel_t;

    // Selection-change state: a pending change waits for SS high
    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } sw_state_t;

    // Index width for n slots; a single slot still gets a 1-bit index
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sd_switch_act_timer.sv
`default_nettype none
// ============================================================================
//  Module      : sd_act_timer
//  Description : Edge detector feeding a counter. In activity mode an event
//                clears the counter, which then counts up and saturates at
//                LIMIT; o_active is high while below LIMIT. In hold mode an
//                event loads LIMIT, the counter counts down, and a registered
//                o_active stays high until the counter reaches zero.
//  Revision    : 1.0  initial release
// ============================================================================
module sd_act_timer
    import sd_switch_pkg::*;
#(
    parameter int MODE  = c_mode_act,
    parameter int LIMIT = 8,
    parameter int CNT_W = 24,
    parameter int SIG_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [SIG_W-1:0] i_sig,
    input  logic             i_trig,
    output logic             o_active
);

    localparam logic [CNT_W-1:0] c_limit = CNT_W'(LIMIT);

    logic [SIG_W-1:0] r_old;
    logic [CNT_W-1:0] r_cnt;
    logic             w_event;

    // Previous-cycle copy of the watched lines; idle level is high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_old <= '1;
        else        r_old <= i_sig;
    end

    assign w_event = i_trig | (i_sig != r_old);

    generate
        if (MODE == c_mode_act) begin : g_act
            // Clear on any line change, otherwise count up and saturate
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)                r_cnt <= c_limit;
                else if (w_event)          r_cnt <= '0;
                else if (r_cnt < c_limit)  r_cnt <= r_cnt + 1'b1;
            end
            assign o_active = (r_cnt < c_limit);
        end else begin : g_hold
            logic r_flag;
            // Load on event (retriggerable), then count down; flag drops as
            // the counter reaches zero
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt  <= '0;
                    r_flag <= 1'b0;
                end else if (w_event) begin
                    r_cnt  <= c_limit;
                    r_flag <= 1'b1;
                end else if (r_cnt != '0) begin
                    r_cnt  <= r_cnt - 1'b1;
                    r_flag <= (r_cnt != CNT_W'(1));
                end
            end
            assign o_active = r_flag;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/sd_switch.sv
`default_nettype none
// ============================================================================
//  Module      : sd_switch
//  Description : Routes the core SPI master to the physical SD slot or one of
//                NUM_IMG virtual cards. Mount/eject pulses pick a target that
//                is committed only while SS is high, raise a retriggerable
//                cold-reset request, and activity drives split LEDs.
//  Revision    : 1.0  initial release
// ============================================================================
module sd_switch
    import sd_switch_pkg::*;
#(
    parameter int  NUM_IMG     = 2,
    parameter int  ACT_TIMEOUT = c_def_act_timeout,
    parameter int  RST_HOLD    = c_def_rst_hold,
    parameter int  CNT_W       = c_def_cnt_w,
    localparam int IDXW        = idx_width(NUM_IMG)
) (
    input  logic               clk_sys,
    input  logic               reset_n,
    input  logic [NUM_IMG-1:0] img_mounted,
    input  logic [NUM_IMG-1:0] img_nz,
    input  logic               spi_sck,
    input  logic               spi_mosi,
    input  logic               spi_ss_n,
    output logic               spi_miso,
    input  logic               phys_miso,
    output logic               phys_sck,
    output logic               phys_mosi,
    output logic               phys_cs_n,
    input  logic [NUM_IMG-1:0] vsd_miso,
    output logic [NUM_IMG-1:0] vsd_ss_n,
    output logic               sel_valid,
    output logic [IDXW-1:0]    sel_idx,
    output logic               reset_req,
    output logic               led_virt,
    output logic               led_phys
);

    sel_t      r_sel;
    sel_t      r_psel;
    sw_state_t r_state;
    sel_t      w_eff;
    sel_t      w_new;
    logic      w_hit;
    logic      w_commit;
    logic      w_act;
    logic      w_miso;
    logic      r_led_virt;
    logic      r_led_phys;

    // Zero-extended copies so the full selection index can address them
    logic [c_slot_max-1:0] w_mnt_pad;
    logic [c_slot_max-1:0] w_nz_pad;
    logic [c_slot_max-1:0] w_vsd_pad;

    assign w_mnt_pad = c_slot_max'(img_mounted);
    assign w_nz_pad  = c_slot_max'(img_nz);
    assign w_vsd_pad = c_slot_max'(vsd_miso);

    // Mount decode: lowest nonzero mount wins; otherwise an eject of the
    // slot that is (or is about to be) routed falls back to physical
    always_comb begin
        w_hit = 1'b0;
        w_new = '0;
        w_eff = (r_state == ST_PENDING) ? r_psel : r_sel;
        for (int i = NUM_IMG - 1; i >= 0; i--) begin
            if (img_mounted[i] && img_nz[i]) begin
                w_hit     = 1'b1;
                w_new.valid = 1'b1;
                w_new.idx   = c_sel_idx_w'(i);
            end
        end
        if (!w_hit && w_eff.valid && w_mnt_pad[w_eff.idx] && !w_nz_pad[w_eff.idx]) begin
            w_hit = 1'b1;
            w_new = '0;
        end
    end

    // Commit only between transactions, while the core holds SS high
    assign w_commit = (r_state == ST_PENDING) && spi_ss_n;

    // Selection FSM: a new target always overwrites the pending one
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_sel   <= '0;
            r_psel  <= '0;
        end else begin
            if (w_commit) r_sel <= r_psel;
            if (w_hit) begin
                r_psel  <= w_new;
                r_state <= ST_PENDING;
            end else if (w_commit) begin
                r_state <= ST_IDLE;
            end
        end
    end

    // Routing from the registered selection
    assign phys_cs_n = r_sel.valid | spi_ss_n;
    assign phys_sck  = spi_sck  & ~phys_cs_n;
    assign phys_mosi = spi_mosi & ~phys_cs_n;
    assign w_miso    = r_sel.valid ? w_vsd_pad[r_sel.idx] : phys_miso;
    assign spi_miso  = w_miso;

    generate
        for (genvar gi = 0; gi < NUM_IMG; gi++) begin : g_vsd
            assign vsd_ss_n[gi] = spi_ss_n |
                                  ~(r_sel.valid & (r_sel.idx == c_sel_idx_w'(gi)));
        end
    endgenerate

    assign sel_valid = r_sel.valid;
    assign sel_idx   = r_sel.idx[IDXW-1:0];

    // Activity: any MOSI/MISO change restarts the LED timeout
    sd_act_timer #(
        .MODE  (c_mode_act),
        .LIMIT (ACT_TIMEOUT),
        .CNT_W (CNT_W),
        .SIG_W (2)
    ) u_act (
        .clk      (clk_sys),
        .rst_n    (reset_n),
        .i_sig    ({spi_mosi, w_miso}),
        .i_trig   (1'b0),
        .o_active (w_act)
    );

    // Cold-reset request: any mount or eject pulse (re)starts the hold
    sd_act_timer #(
        .MODE  (c_mode_hold),
        .LIMIT (RST_HOLD),
        .CNT_W (CNT_W),
        .SIG_W (1)
    ) u_rst (
        .clk      (clk_sys),
        .rst_n    (reset_n),
        .i_sig    (1'b1),
        .i_trig   (|img_mounted),
        .o_active (reset_req)
    );

    // LEDs registered and split by which side is currently routed
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_led_virt <= 1'b0;
            r_led_phys <= 1'b0;
        end else begin
            r_led_virt <= w_act &  r_sel.valid;
            r_led_phys <= w_act & ~r_sel.valid;
        end
    end

    assign led_virt = r_led_virt;
    assign led_phys = r_led_phys;

endmodule
`default_nettype wire

// File: tb/tb_sd_switch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sd_switch
//  Description : Directed self-checking bench for sd_switch (NUM_IMG=2,
//                ACT_TIMEOUT=8, RST_HOLD=16).
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_sd_switch;

    logic       clk_sys = 1'b0;
    logic       reset_n;
    logic [1:0] img_mounted, img_nz;
    logic       spi_sck, spi_mosi, spi_ss_n, spi_miso;
    logic       phys_miso, phys_sck, phys_mosi, phys_cs_n;
    logic [1:0] vsd_miso, vsd_ss_n;
    logic       sel_valid;
    logic [0:0] sel_idx;
    logic       reset_req, led_virt, led_phys;

    int total = 0;
    int bad   = 0;

    sd_switch #(
        .NUM_IMG     (2),
        .ACT_TIMEOUT (8),
        .RST_HOLD    (16),
        .CNT_W       (24)
    ) dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .img_mounted (img_mounted),
        .img_nz      (img_nz),
        .spi_sck     (spi_sck),
        .spi_mosi    (spi_mosi),
        .spi_ss_n    (spi_ss_n),
        .spi_miso    (spi_miso),
        .phys_miso   (phys_miso),
        .phys_sck    (phys_sck),
        .phys_mosi   (phys_mosi),
        .phys_cs_n   (phys_cs_n),
        .vsd_miso    (vsd_miso),
        .vsd_ss_n    (vsd_ss_n),
        .sel_valid   (sel_valid),
        .sel_idx     (sel_idx),
        .reset_req   (reset_req),
        .led_virt    (led_virt),
        .led_phys    (led_phys)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    // One-cycle mount pulse captured by the next edge
    task automatic pulse(input logic [1:0] m, input logic [1:0] nz);
        img_mounted = m;
        img_nz      = nz;
        tick();
        img_mounted = 2'b00;
        img_nz      = 2'b00;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; img_mounted = 2'b00; img_nz = 2'b00;
        spi_sck = 1'b0; spi_mosi = 1'b1; spi_ss_n = 1'b1;
        phys_miso = 1'b1; vsd_miso = 2'b11;
        ticks(3);
        total++; if (sel_valid !== 1'b0) begin bad++; $display("FAIL rst_sel_valid got=%0b exp=0", sel_valid); end
        total++; if (sel_idx !== 1'b0) begin bad++; $display("FAIL rst_sel_idx got=%0b exp=0", sel_idx); end
        total++; if (reset_req !== 1'b0) begin bad++; $display("FAIL rst_reset_req got=%0b exp=0", reset_req); end
        total++; if ({led_virt, led_phys} !== 2'b00) begin bad++; $display("FAIL rst_leds got=%b exp=00", {led_virt, led_phys}); end
        total++; if (vsd_ss_n !== 2'b11) begin bad++; $display("FAIL rst_vsd_ss_n got=%b exp=11", vsd_ss_n); end
        reset_n = 1'b1;
        ticks(4);
        total++; if ({led_virt, led_phys, reset_req, sel_valid} !== 4'b0000) begin bad++; $display("FAIL post_rst_idle got=%b exp=0000", {led_virt, led_phys, reset_req, sel_valid}); end
    endtask

    task automatic test_phys_activity();
        spi_ss_n = 1'b0;
        spi_sck  = 1'b1;
        #1;
        total++; if (phys_cs_n !== 1'b0) begin bad++; $display("FAIL phys_cs_n got=%0b exp=0", phys_cs_n); end
        total++; if (phys_sck !== 1'b1) begin bad++; $display("FAIL phys_sck got=%0b exp=1", phys_sck); end
        total++; if (vsd_ss_n !== 2'b11) begin bad++; $display("FAIL phys_vsd_ss_n got=%b exp=11", vsd_ss_n); end
        spi_mosi = 1'b0;
        #1;
        total++; if (phys_mosi !== 1'b0) begin bad++; $display("FAIL phys_mosi got=%0b exp=0", phys_mosi); end
        tick();              // change seen, counter cleared
        ticks(8);            // LED lit from the first edge after the clear
        total++; if (led_phys !== 1'b1) begin bad++; $display("FAIL led_phys_on got=%0b exp=1", led_phys); end
        total++; if (led_virt !== 1'b0) begin bad++; $display("FAIL led_virt_off got=%0b exp=0", led_virt); end
        tick();
        total++; if (led_phys !== 1'b0) begin bad++; $display("FAIL led_phys_timeout got=%0b exp=0", led_phys); end
        spi_ss_n = 1'b1; spi_sck = 1'b0; spi_mosi = 1'b1;
        ticks(12);
    endtask

    task automatic test_mount_idle();
        pulse(2'b10, 2'b10);
        total++; if (sel_valid !== 1'b0) begin bad++; $display("FAIL idle_mount_early got=%0b exp=0", sel_valid); end
        total++; if (reset_req !== 1'b1) begin bad++; $display("FAIL idle_rr_start got=%0b exp=1", reset_req); end
        tick();
        total++; if ({sel_valid, sel_idx} !== 2'b11) begin bad++; $display("FAIL idle_mount_commit got=%b exp=11", {sel_valid, sel_idx}); end
        for (int k = 3; k <= 16; k++) begin
            tick();
            total++; if (reset_req !== 1'b1) begin bad++; $display("FAIL idle_rr_hold edge=%0d got=%0b exp=1", k, reset_req); end
        end
        tick();
        total++; if (reset_req !== 1'b0) begin bad++; $display("FAIL idle_rr_end got=%0b exp=0", reset_req); end
        spi_ss_n = 1'b0;
        vsd_miso = 2'b01;
        #1;
        total++; if (vsd_ss_n !== 2'b01) begin bad++; $display("FAIL virt_vsd_ss_n got=%b exp=01", vsd_ss_n); end
        total++; if (phys_cs_n !== 1'b1) begin bad++; $display("FAIL virt_phys_cs_n got=%0b exp=1", phys_cs_n); end
        total++; if (spi_miso !== 1'b0) begin bad++; $display("FAIL virt_miso got=%0b exp=0", spi_miso); end
        ticks(2);
        total++; if ({led_virt, led_phys} !== 2'b10) begin bad++; $display("FAIL virt_leds got=%b exp=10", {led_virt, led_phys}); end
        vsd_miso = 2'b11;
    endtask

    task automatic test_mount_busy();
        // spi_ss_n still low: transaction in progress
        pulse(2'b01, 2'b01);
        ticks(3);
        total++; if ({sel_valid, sel_idx} !== 2'b11) begin bad++; $display("FAIL busy_hold_sel got=%b exp=11", {sel_valid, sel_idx}); end
        total++; if (vsd_ss_n !== 2'b01) begin bad++; $display("FAIL busy_hold_vsd got=%b exp=01", vsd_ss_n); end
        spi_ss_n = 1'b1;
        #1;
        total++; if (sel_idx !== 1'b1) begin bad++; $display("FAIL busy_pre_commit got=%0b exp=1", sel_idx); end
        tick();
        total++; if ({sel_valid, sel_idx} !== 2'b10) begin bad++; $display("FAIL busy_commit got=%b exp=10", {sel_valid, sel_idx}); end
        spi_ss_n = 1'b0;
        #1;
        total++; if (vsd_ss_n !== 2'b10) begin bad++; $display("FAIL busy_new_vsd got=%b exp=10", vsd_ss_n); end
        spi_ss_n = 1'b1;
        ticks(20);
    endtask

    task automatic test_simul_eject();
        pulse(2'b10, 2'b10);
        tick();
        total++; if ({sel_valid, sel_idx} !== 2'b11) begin bad++; $display("FAIL sim_pre got=%b exp=11", {sel_valid, sel_idx}); end
        pulse(2'b11, 2'b11);
        tick();
        total++; if ({sel_valid, sel_idx} !== 2'b10) begin bad++; $display("FAIL sim_lowest got=%b exp=10", {sel_valid, sel_idx}); end
        pulse(2'b01, 2'b00);
        tick();
        total++; if (sel_valid !== 1'b0) begin bad++; $display("FAIL eject_sel got=%0b exp=0", sel_valid); end
        spi_ss_n = 1'b0;
        #1;
        total++; if ({phys_cs_n, vsd_ss_n} !== 3'b011) begin bad++; $display("FAIL eject_route got=%b exp=011", {phys_cs_n, vsd_ss_n}); end
        spi_ss_n = 1'b1;
        ticks(20);
        total++; if (reset_req !== 1'b0) begin bad++; $display("FAIL eject_rr_idle got=%0b exp=0", reset_req); end
        pulse(2'b10, 2'b00);
        total++; if (reset_req !== 1'b1) begin bad++; $display("FAIL other_eject_rr got=%0b exp=1", reset_req); end
        ticks(2);
        total++; if (sel_valid !== 1'b0) begin bad++; $display("FAIL other_eject_sel got=%0b exp=0", sel_valid); end
        ticks(20);
    endtask

    task automatic test_retrigger();
        img_mounted = 2'b10; img_nz = 2'b10;
        tick();              // edge 1 loads the hold counter
        img_mounted = 2'b00; img_nz = 2'b00;
        total++; if (reset_req !== 1'b1) begin bad++; $display("FAIL retrig_start got=%0b exp=1", reset_req); end
        for (int k = 2; k <= 25; k++) begin
            if (k == 10) begin img_mounted = 2'b10; img_nz = 2'b10; end
            tick();
            img_mounted = 2'b00; img_nz = 2'b00;
            total++; if (reset_req !== 1'b1) begin bad++; $display("FAIL retrig_hold edge=%0d got=%0b exp=1", k, reset_req); end
        end
        tick();
        total++; if (reset_req !== 1'b0) begin bad++; $display("FAIL retrig_end got=%0b exp=0", reset_req); end
    endtask

    task automatic test_async_reset();
        // slot 1 routed from the retrigger test; queue slot 0 mid-transaction
        spi_ss_n = 1'b0;
        pulse(2'b01, 2'b01);
        total++; if ({sel_valid, sel_idx, reset_req} !== 3'b111) begin bad++; $display("FAIL ar_pre got=%b exp=111", {sel_valid, sel_idx, reset_req}); end
        #2;
        reset_n = 1'b0;
        #1;
        total++; if ({sel_valid, sel_idx, reset_req} !== 3'b000) begin bad++; $display("FAIL ar_immediate got=%b exp=000", {sel_valid, sel_idx, reset_req}); end
        total++; if ({vsd_ss_n, led_virt, led_phys} !== 4'b1100) begin bad++; $display("FAIL ar_outputs got=%b exp=1100", {vsd_ss_n, led_virt, led_phys}); end
        tick();
        reset_n  = 1'b1;
        spi_ss_n = 1'b1;
        ticks(3);
        total++; if ({sel_valid, reset_req} !== 2'b00) begin bad++; $display("FAIL ar_pending_lost got=%b exp=00", {sel_valid, reset_req}); end
    endtask

    initial begin
        test_reset();
        test_phys_activity();
        test_mount_idle();
        test_mount_busy();
        test_simul_eject();
        test_retrigger();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
